riscv_stream_bridge: RTL and testbench
======================================

RISCV_STREAM_BRIDGE -- requirements
Module: riscv_stream_bridge

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of stream channels in each direction (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream word width (1..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per channel FIFO (power of two, >=2).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1000_0000, base of the 512-byte register window.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  picorv32 native bus request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  write strobes; 0 = read.
- mem_ready  out  1  one-cycle transfer acknowledge.
- mem_rdata  out  32  read data, valid with mem_ready.
- din  in  NUM_PORTS*DATA_WIDTH  inbound stream data, channel i at slice i.
- val_in  in  NUM_PORTS  inbound valid.
- ready_upward  out  NUM_PORTS  inbound ready.
- dout  out  NUM_PORTS*DATA_WIDTH  outbound stream data.
- val_out  out  NUM_PORTS  outbound valid.
- ready_downward  in  NUM_PORTS  outbound ready.
- print_out  out  49  console byte strobe {valid, 40'h0, byte}.

Function
REQ-006 SHALL decode offsets from BASE_ADDR: 0x000+4*i = channel i data (write pushes TX FIFO i, read pops RX FIFO i); 0x100 = RX_STATUS (bit i = RX FIFO i non-empty); 0x104 = TX_STATUS (bit i = TX FIFO i not full); 0x108 = PRINT (write only).
REQ-007 SHALL treat any non-zero mem_wstrb as a full-word write; store mem_wdata[DATA_WIDTH-1:0].
REQ-008 SHALL assert mem_ready for exactly one cycle, at the earliest one cycle after mem_valid is sampled with a satisfiable request; mem_rdata registered in the same cycle, zero-extended.
REQ-009 SHALL stall (mem_ready low) a write to a full TX FIFO until an entry frees, then push and acknowledge on the next cycle.
REQ-010 SHALL stall a read of an empty RX FIFO until data arrives, then pop and acknowledge on the next cycle.
REQ-011 SHALL ignore mem_valid in the cycle immediately after a mem_ready pulse (no double push/pop).
REQ-012 SHALL acknowledge in-window unmapped offsets and channel indices >= NUM_PORTS after one cycle; writes discarded, reads return 0.
REQ-013 SHALL NOT respond (mem_ready stays 0) to addresses outside the window.
REQ-014 SHALL, on a PRINT write acknowledge, drive print_out = {1'b1, 40'h0, mem_wdata[7:0]} for one cycle; otherwise print_out = 0.
REQ-015 SHALL drive val_out[i] = TX FIFO i non-empty, dout slice = TX head; pop when val_out[i] & ready_downward[i].
REQ-016 SHALL drive ready_upward[i] = RX FIFO i not full; push din slice when val_in[i] & ready_upward[i].
REQ-017 SHALL allow simultaneous push and pop on a non-full, non-empty FIFO, leaving occupancy unchanged; stream pop and CPU push in the same cycle on a full TX FIFO SHALL pop only (push stalls one more cycle).
REQ-018 SHALL wrap FIFO pointers modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH+1).
REQ-019 SHALL preserve per-channel FIFO order; channels fully independent.

Reset
REQ-020 SHALL, while resetn=0, asynchronously empty all FIFOs and clear mem_ready, mem_rdata, print_out, val_out, the post-ack mask; ready_upward = all ones after release.
REQ-021 SHALL drop any in-flight stalled transaction on reset without acknowledge.

Structure
REQ-022 SHALL place register offsets (0x100, 0x104, 0x108) and the print-word layout in package riscv_stream_pkg.
REQ-023 SHALL instantiate sub-module stream_fifo (params DATA_WIDTH, FIFO_DEPTH) 2*NUM_PORTS times via generate.

Verification
REQ-024 Write 0x1234_5678 to BASE+0x008, ready_downward[2]=1 -> mem_ready one cycle later; val_out[2]=1, dout slice 2 = 0x1234_5678 next cycle.
REQ-025 FIFO_DEPTH=4, ready_downward[0]=0, five writes to BASE+0x000 -> fifth stalls, TX_STATUS bit0=0; raise ready_downward[0] one cycle -> fifth acknowledged.
REQ-026 Read BASE+0x004 with RX1 empty -> stall; val_in[1]=1, din=0xAB -> mem_rdata=0xAB with mem_ready, RX_STATUS bit1 back to 0.
REQ-027 Write 0x41 to BASE+0x108 -> print_out = {1'b1, 40'h0, 8'h41} one cycle, then 0.
REQ-028 Deassert resetn during a stalled read -> no mem_ready; after release all val_out=0, ready_upward all ones, RX_STATUS=0.
REQ-029 Read BASE+0x01C with NUM_PORTS=5 -> mem_ready after one cycle, mem_rdata=0, no FIFO state change.

Source files
------------

// File: rtl/riscv_stream_pkg.sv
// Register map, decoded-request record and console word layout shared by
// the picorv32 stream bridge and its FIFOs.
package riscv_stream_pkg;

  localparam logic [8:0] OFF_RX_STATUS = 9'h100;
  localparam logic [8:0] OFF_TX_STATUS = 9'h104;
  localparam logic [8:0] OFF_PRINT     = 9'h108;
  localparam int         WIN_BYTES     = 512;

  localparam int PRINT_W   = 49;
  localparam int PRINT_PAD = 40;
  typedef logic [PRINT_W-1:0] print_word_t;

  typedef struct packed {
    logic       in_win;
    logic       is_wr;
    logic       is_chan;
    logic       is_rxs;
    logic       is_txs;
    logic       is_print;
    logic [5:0] chan;
  } req_dec_t;

  function automatic print_word_t make_print(input logic [7:0] b);
    return {1'b1, {PRINT_PAD{1'b0}}, b};
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock FIFO with show-ahead head; push is refused when full and pop
// when empty, so a full FIFO seeing both in one cycle only pops.
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_stream_bridge.sv
// picorv32 native-bus slave exposing NUM_PORTS TX/RX stream FIFO pairs,
// two status registers and a console print strobe in a 512-byte window.
module riscv_stream_bridge
  import riscv_stream_pkg::*;
#(
  parameter int          NUM_PORTS  = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            mem_valid,
  input  logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_wdata,
  input  logic [3:0]                      mem_wstrb,
  output logic                            mem_ready,
  output logic [31:0]                     mem_rdata,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
  input  logic [NUM_PORTS-1:0]            val_in,
  output logic [NUM_PORTS-1:0]            ready_upward,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]            val_out,
  input  logic [NUM_PORTS-1:0]            ready_downward,
  output logic [48:0]                     print_out
);
  localparam int STAGES = 1;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] din_v, tx_head, rx_head;
  logic [NUM_PORTS-1:0] tx_empty, tx_full, rx_empty, rx_full;
  logic [NUM_PORTS-1:0] rx_nonempty, tx_notfull;
  logic [NUM_PORTS-1:0] chan_sel, tx_push, rx_pop;

  logic [31:0] offset;
  req_dec_t    dec;
  logic        chan_ok, sat, fire;
  logic [31:0] rd_val;
  // [0] is the ack pulse itself, [1] masks the cycle after it.
  logic [STAGES:0] vld_pipe;
  logic        unused_ok;

  assign din_v        = din;
  assign dout         = tx_head;
  assign val_out      = ~tx_empty;
  assign ready_upward = ~rx_full;
  assign rx_nonempty  = ~rx_empty;
  assign tx_notfull   = ~tx_full;
  assign mem_ready    = vld_pipe[0];
  assign unused_ok    = ^{offset[1:0], mem_wdata};

  assign offset = mem_addr - BASE_ADDR;

  always_comb begin
    dec          = '0;
    dec.in_win   = (offset < 32'(WIN_BYTES));
    dec.is_wr    = |mem_wstrb;
    dec.is_chan  = ~offset[8];
    dec.is_rxs   = (offset[8:2] == OFF_RX_STATUS[8:2]);
    dec.is_txs   = (offset[8:2] == OFF_TX_STATUS[8:2]);
    dec.is_print = (offset[8:2] == OFF_PRINT[8:2]);
    dec.chan     = offset[7:2];
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sel
    assign chan_sel[i] = dec.is_chan && (dec.chan == 6'(i));
  end
  assign chan_ok = |chan_sel;

  // Only a data access to a real channel can stall; everything else in
  // the window completes immediately.
  always_comb begin
    sat = 1'b1;
    if (chan_ok) sat = dec.is_wr ? |(chan_sel & tx_notfull) : |(chan_sel & rx_nonempty);
  end

  assign fire = mem_valid & ~vld_pipe[0] & ~vld_pipe[1] & dec.in_win & sat;

  always_comb begin
    rd_val = '0;
    if (dec.is_rxs)      rd_val = 32'(rx_nonempty);
    else if (dec.is_txs) rd_val = 32'(tx_notfull);
    else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (chan_sel[i]) rd_val = 32'(rx_head[i]);
    end
  end

  assign tx_push = {NUM_PORTS{fire & dec.is_wr}} & chan_sel;
  assign rx_pop  = {NUM_PORTS{fire & ~dec.is_wr}} & chan_sel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe  <= '0;
      mem_rdata <= '0;
      print_out <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], fire};
      mem_rdata <= (fire && !dec.is_wr) ? rd_val : '0;
      print_out <= (fire && dec.is_wr && dec.is_print) ? make_print(mem_wdata[7:0]) : '0;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
    stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (clk),
      .resetn(resetn),
      .push  (tx_push[i]),
      .wdata (mem_wdata[DATA_WIDTH-1:0]),
      .pop   (ready_downward[i]),
      .rdata (tx_head[i]),
      .empty (tx_empty[i]),
      .full  (tx_full[i])
    );
    stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (clk),
      .resetn(resetn),
      .push  (val_in[i]),
      .wdata (din_v[i]),
      .pop   (rx_pop[i]),
      .rdata (rx_head[i]),
      .empty (rx_empty[i]),
      .full  (rx_full[i])
    );
  end

endmodule

// File: tb/tb_riscv_stream_bridge.sv
// Bench for riscv_stream_bridge: register-map vector table, handshake corner
// sequences, random traffic against per-channel stream scoreboards.
module tb_riscv_stream_bridge;
  localparam int          NP   = 5;
  localparam int          DW   = 32;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk, resetn;
  logic mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [NP-1:0][DW-1:0] din, dout;
  logic [NP-1:0] val_in, ready_upward, val_out, ready_downward;
  logic [48:0] print_out;

  int checks = 0;
  int fails  = 0;
  logic [31:0] tx_exp [NP][$];
  logic [31:0] rx_mdl [NP][$];

  riscv_stream_bridge #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .din(din), .val_in(val_in), .ready_upward(ready_upward),
    .dout(dout), .val_out(val_out), .ready_downward(ready_downward),
    .print_out(print_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stream-side monitor: TX pops compared against the scoreboard, RX pushes
  // recorded into the model, both on the values the next posedge will see.
  always begin : mon
    logic [31:0] e;
    @(negedge clk); #1;
    if (resetn) begin
      for (int c = 0; c < NP; c++) begin
        if (val_out[c] && ready_downward[c]) begin
          if (tx_exp[c].size() == 0) begin
            checks++; fails++;
            $display("FAIL tx_unexpected ch=%0d actual=%0h required=none", c, dout[c]);
          end else begin
            e = tx_exp[c].pop_front();
            check($sformatf("tx_data_ch%0d", c), dout[c], e);
          end
        end
        if (val_in[c] && ready_upward[c]) rx_mdl[c].push_back(din[c]);
      end
    end
  end

  task automatic sb_update(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] rdata);
    logic [31:0] off, e;
    int ch;
    off = addr - BASE;
    ch  = int'(off >> 2);
    if (off < 32'h20 && ch < NP) begin
      if (wstrb != 4'h0) tx_exp[ch].push_back(wdata);
      else if (rx_mdl[ch].size() == 0) begin
        checks++; fails++;
        $display("FAIL rx_sb ch=%0d actual=%0h required=none", ch, rdata);
      end else begin
        e = rx_mdl[ch].pop_front();
        check($sformatf("rx_sb_ch%0d", ch), rdata, e);
      end
    end
  endtask

  task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            input int bound, output logic got, output logic [31:0] rdata, output int lat);
    got = 1'b0; rdata = '0; lat = 0;
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    while (!got && lat < bound) begin
      @(negedge clk);
      lat++;
      if (mem_ready) begin
        got = 1'b1;
        rdata = mem_rdata;
      end
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    if (got) sb_update(addr, wdata, wstrb, rdata);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[16];

  initial begin
    logic        g;
    logic [31:0] rd;
    int          lat;
    logic [48:0] pe;
    int          ch;

    tbl[0]  = '{BASE + 32'h100, 32'h0,         4'h0, 1'b1, 32'h01};
    tbl[1]  = '{BASE + 32'h104, 32'h0,         4'h0, 1'b1, 32'h1F};
    tbl[2]  = '{BASE + 32'h00C, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
    tbl[3]  = '{BASE + 32'h010, 32'hCAFE_0001, 4'h1, 1'b1, 32'h0};
    tbl[4]  = '{BASE + 32'h000, 32'h0,         4'h0, 1'b1, 32'h11};
    tbl[5]  = '{BASE + 32'h000, 32'h0,         4'h0, 1'b1, 32'h22};
    tbl[6]  = '{BASE + 32'h100, 32'h0,         4'h0, 1'b1, 32'h00};
    tbl[7]  = '{BASE + 32'h01C, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[8]  = '{BASE + 32'h014, 32'h55,        4'hF, 1'b1, 32'h0};
    tbl[9]  = '{BASE + 32'h10C, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[10] = '{BASE + 32'h108, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[11] = '{BASE + 32'h104, 32'hFFFF,      4'hF, 1'b1, 32'h0};
    tbl[12] = '{BASE + 32'h104, 32'h0,         4'h0, 1'b1, 32'h1F};
    tbl[13] = '{BASE + 32'h200, 32'h0,         4'h0, 1'b0, 32'h0};
    tbl[14] = '{BASE - 32'h4,   32'h77,        4'hF, 1'b0, 32'h0};
    tbl[15] = '{BASE + 32'h0FC, 32'h0,         4'h0, 1'b1, 32'h0};

    resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    din = '0; val_in = '0; ready_downward = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_val_out", val_out, 0);
    check("rst_print_out", print_out, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ready_upward", ready_upward, 5'h1F);

    // Preload RX0 with two words for the table reads.
    val_in[0] = 1'b1; din[0] = 32'h11;
    @(negedge clk); din[0] = 32'h22;
    @(negedge clk); val_in = '0;

    for (int i = 0; i < 16; i++) begin
      cpu_access(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].ack ? 20 : 6, g, rd, lat);
      check($sformatf("vec%0d_ack", i), g, tbl[i].ack);
      if (tbl[i].ack) check($sformatf("vec%0d_lat", i), lat, 1);
      if (tbl[i].ack && tbl[i].wstrb == 4'h0) check($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
    end

    // Write to channel 2 with the sink ready: head visible right after ack.
    ready_downward = 5'b00100;
    cpu_access(BASE + 32'h008, 32'h1234_5678, 4'hF, 20, g, rd, lat);
    check("ch2_ack_lat", lat, 1);
    check("ch2_val_out", val_out[2], 1);
    check("ch2_dout", dout[2], 32'h1234_5678);
    @(negedge clk);
    ready_downward = '0;

    // Fill TX0, fifth write stalls until a single stream pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      cpu_access(BASE, 32'hA0 + 32'(i), 4'hF, 20, g, rd, lat);
      check($sformatf("fill%0d_lat", i), lat, 1);
    end
    cpu_access(BASE + 32'h104, 32'h0, 4'h0, 20, g, rd, lat);
    check("tx_status_full0", rd, 32'h1E);
    fork
      cpu_access(BASE, 32'hA4, 4'hF, 30, g, rd, lat);
      begin
        repeat (6) @(negedge clk);
        ready_downward[0] = 1'b1;
        @(negedge clk);
        ready_downward[0] = 1'b0;
      end
    join
    check("full_wr_ack", g, 1);
    check("full_wr_lat", lat, 6);
    @(negedge clk);
    ready_downward = '1;
    repeat (8) @(negedge clk);
    ready_downward = '0;

    // Read of empty RX1 stalls until a word streams in.
    fork
      cpu_access(BASE + 32'h004, 32'h0, 4'h0, 30, g, rd, lat);
      begin
        repeat (5) @(negedge clk);
        val_in[1] = 1'b1; din[1] = 32'hAB;
        @(negedge clk);
        val_in[1] = 1'b0;
      end
    join
    check("empty_rd_ack", g, 1);
    check("empty_rd_lat", lat, 5);
    check("empty_rd_data", rd, 32'hAB);
    cpu_access(BASE + 32'h100, 32'h0, 4'h0, 20, g, rd, lat);
    check("rx_status_after", rd, 32'h0);

    // Console strobe.
    pe = '0; pe[48] = 1'b1; pe[7:0] = 8'h41;
    cpu_access(BASE + 32'h108, 32'h41, 4'hF, 20, g, rd, lat);
    check("print_ack", g, 1);
    check("print_word", print_out, pe);
    @(negedge clk);
    check("print_clear", print_out, 0);

    // Random traffic on both sides; only issue accesses that must complete.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ready_downward = NP'($urandom);
      val_in = NP'($urandom);
      for (int c = 0; c < NP; c++) din[c] = $urandom;
      ch = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 1) == 1 && (tx_exp[ch].size() < FD || ready_downward[ch])) begin
        cpu_access(BASE + 32'(ch * 4), $urandom, 4'(1 << $urandom_range(0, 3)), 30, g, rd, lat);
        check("rnd_wr_ack", g, 1);
      end else if (rx_mdl[ch].size() > 0) begin
        cpu_access(BASE + 32'(ch * 4), 32'h0, 4'h0, 30, g, rd, lat);
        check("rnd_rd_ack", g, 1);
      end
    end
    val_in = '0;
    ready_downward = '1;
    repeat (10) @(negedge clk);
    ready_downward = '0;
    check("tx_drain", tx_exp[0].size() + tx_exp[1].size() + tx_exp[2].size()
                      + tx_exp[3].size() + tx_exp[4].size(), 0);

    // Empty RX2, leave data in TX1, then reset during a stalled RX2 read.
    for (int i = 0; i < 8 && rx_mdl[2].size() > 0; i++)
      cpu_access(BASE + 32'h008, 32'h0, 4'h0, 20, g, rd, lat);
    cpu_access(BASE + 32'h004, 32'h99, 4'hF, 20, g, rd, lat);
    check("pre_rst_val_out1", val_out[1], 1);
    fork
      cpu_access(BASE + 32'h008, 32'h0, 4'h0, 12, g, rd, lat);
      begin
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        for (int c = 0; c < NP; c++) begin
          tx_exp[c].delete();
          rx_mdl[c].delete();
        end
        @(negedge clk);
        check("in_rst_mem_ready", mem_ready, 0);
        check("in_rst_val_out", val_out, 0);
        resetn = 1'b1;
      end
    join
    check("rst_stall_no_ack", g, 0);
    check("post_rst_val_out", val_out, 0);
    check("post_rst_ready_up", ready_upward, 5'h1F);
    cpu_access(BASE + 32'h100, 32'h0, 4'h0, 20, g, rd, lat);
    check("post_rst_rx_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
